// File: rtl/axi_mem_rd_engine_if.sv
// AXI read-address / read-data channels plus the simple memory port of
// axi_mem_rd_engine, bundled so the engine takes one bus port.
interface axi_mem_rd_engine_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   ARID;
    logic [31:0]           ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic [1:0]            ARLOCK;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_err;

    // Engine side
    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output mem_req, mem_addr,
        input  mem_ready, mem_rdata, mem_err
    );

    // AXI master / memory model side
    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  mem_req, mem_addr,
        output mem_ready, mem_rdata, mem_err
    );
endinterface

// File: rtl/axi_mem_rd_engine.sv
// AXI read engine: queues AR bursts, expands them into single-beat memory
// reads (fixed 1-cycle read latency) and returns R beats through a 2-entry
// output buffer. WRAP bursts are supported only when AXI_MEM_RD_WRAP_EN is
// defined; otherwise ARBURST=2'b10 is answered as an illegal burst.
module axi_mem_rd_engine #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int AR_DEPTH   = 4
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi_mem_rd_engine_if.slave bus
);
    localparam int PW       = $clog2(AR_DEPTH);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic [1:0]          lock;
    } ar_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_t;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // ---------------- AR queue ----------------
    ar_t           fifo_q [AR_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   ar_cnt_q;   // entries waiting in the queue
    logic [PW:0]   os_cnt_q;   // queued bursts plus the one being expanded
    ar_t           ar_in, head;
    logic          arready, ar_push, ar_pop, ar_empty;

    // ---------------- beat generator ----------------
    state_t              state_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          cnt_q;    // beats left after the current one
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [1:0]          lock_q;
    logic                ill_q;
`ifdef AXI_MEM_RD_WRAP_EN
    logic [31:0]         wmask_q;
`endif
    logic [31:0]         head_addr;
    logic                head_ill;
    logic                credit_ok, issue, last_issue;

    // One-deep read pipeline: the beat issued last cycle
    logic                pend_vld_q, pend_last_q, pend_ill_q;
    logic [ID_WIDTH-1:0] pend_id_q;
    logic [1:0]          pend_lock_q;

    // ---------------- R buffer ----------------
    r_t         rb_q [2];
    logic       rb_wp_q, rb_rp_q;
    logic [1:0] rb_cnt_q;
    logic [1:0] rb_free;
    logic       rb_push, rb_pop;
    r_t         rb_in;

    // A slot stays claimed until the burst's last beat issues, so at most
    // AR_DEPTH bursts are outstanding including the active one.
    assign arready  = !ARESET && (os_cnt_q != (PW+1)'(AR_DEPTH));
    assign ar_push  = bus.ARVALID && arready;
    assign ar_empty = (ar_cnt_q == '0);
    assign ar_in    = '{id: bus.ARID, addr: bus.ARADDR, len: bus.ARLEN,
                        size: bus.ARSIZE, burst: bus.ARBURST, lock: bus.ARLOCK};
    assign head     = fifo_q[rd_ptr_q];

    // Issue only when every outstanding read is guaranteed an R-buffer slot
    assign rb_free    = 2'd2 - rb_cnt_q;
    assign credit_ok  = rb_free > {1'b0, pend_vld_q};
    assign issue      = (state_q == S_BURST) && credit_ok && (ill_q || bus.mem_ready);
    assign last_issue = issue && (cnt_q == 8'd0);
    assign ar_pop     = !ar_empty && ((state_q == S_IDLE) || last_issue);

    // Decode the queue head: aligned start address and legality
    always_comb begin
        head_addr = head.addr & ~((32'h1 << head.size) - 32'h1);
        head_ill  = (int'(head.size) > MAX_SIZE) || (head.burst == 2'b11);
`ifdef AXI_MEM_RD_WRAP_EN
        if (head.burst == BURST_WRAP &&
            !(head.len == 8'd1 || head.len == 8'd3 || head.len == 8'd7 || head.len == 8'd15))
            head_ill = 1'b1;
`else
        if (head.burst == BURST_WRAP)
            head_ill = 1'b1;
`endif
    end

    // Address of the following beat in the active burst
    always_comb begin
        addr_d = addr_q;
        case (burst_q)
            BURST_INCR: addr_d = addr_q + (32'h1 << size_q);
`ifdef AXI_MEM_RD_WRAP_EN
            BURST_WRAP: addr_d = (addr_q & ~wmask_q) | ((addr_q + (32'h1 << size_q)) & wmask_q);
`endif
            default:    addr_d = addr_q;
        endcase
    end

    // Queue payload storage (pointers carry the reset state)
    always_ff @(posedge ACLK) begin
        if (ar_push) fifo_q[wr_ptr_q] <= ar_in;
    end

    // Queue pointers and occupancy counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ar_cnt_q <= '0;
            os_cnt_q <= '0;
        end else begin
            if (ar_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (ar_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            ar_cnt_q <= ar_cnt_q + (PW+1)'(ar_push) - (PW+1)'(ar_pop);
            os_cnt_q <= os_cnt_q + (PW+1)'(ar_push) - (PW+1)'(last_issue);
        end
    end

    // Beat generator FSM and the one-cycle read pipeline behind it
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= '0;
            ill_q       <= 1'b0;
`ifdef AXI_MEM_RD_WRAP_EN
            wmask_q     <= '0;
`endif
            pend_vld_q  <= 1'b0;
            pend_last_q <= 1'b0;
            pend_ill_q  <= 1'b0;
            pend_id_q   <= '0;
            pend_lock_q <= '0;
        end else begin
            pend_vld_q <= issue;
            if (issue) begin
                pend_id_q   <= id_q;
                pend_last_q <= (cnt_q == 8'd0);
                pend_ill_q  <= ill_q;
                pend_lock_q <= lock_q;
            end
            if (ar_pop) begin
                // Load next burst; from BURST this chains with no bubble
                state_q <= S_BURST;
                id_q    <= head.id;
                addr_q  <= head_addr;
                cnt_q   <= head.len;
                size_q  <= head.size;
                burst_q <= head.burst;
                lock_q  <= head.lock;
                ill_q   <= head_ill;
`ifdef AXI_MEM_RD_WRAP_EN
                wmask_q <= ((32'(head.len) + 32'd1) << head.size) - 32'd1;
`endif
            end else if (issue) begin
                if (cnt_q == 8'd0) begin
                    state_q <= S_IDLE;
                end else begin
                    cnt_q  <= cnt_q - 8'd1;
                    addr_q <= addr_d;
                end
            end
        end
    end

    assign rb_push = pend_vld_q;
    assign rb_pop  = (rb_cnt_q != 2'd0) && bus.RREADY;

    // Build the R beat from the memory response (illegal beats never read memory)
    always_comb begin
        rb_in.id   = pend_id_q;
        rb_in.last = pend_last_q;
        rb_in.data = pend_ill_q ? '0 : bus.mem_rdata;
        if (pend_ill_q || bus.mem_err) rb_in.resp = RESP_SLVERR;
        else if (pend_lock_q == 2'b01) rb_in.resp = RESP_EXOKAY;
        else                           rb_in.resp = RESP_OKAY;
    end

    // Two-entry R output FIFO; head stays put while stalled
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rb_q[0]  <= '0;
            rb_q[1]  <= '0;
            rb_wp_q  <= 1'b0;
            rb_rp_q  <= 1'b0;
            rb_cnt_q <= 2'd0;
        end else begin
            if (rb_push) begin
                rb_q[rb_wp_q] <= rb_in;
                rb_wp_q       <= ~rb_wp_q;
            end
            if (rb_pop) rb_rp_q <= ~rb_rp_q;
            rb_cnt_q <= rb_cnt_q + 2'(rb_push) - 2'(rb_pop);
        end
    end

    // Outputs forced to zero while reset is held
    assign bus.ARREADY  = arready;
    assign bus.RVALID   = !ARESET && (rb_cnt_q != 2'd0);
    assign bus.RID      = ARESET ? '0 : rb_q[rb_rp_q].id;
    assign bus.RDATA    = ARESET ? '0 : rb_q[rb_rp_q].data;
    assign bus.RRESP    = ARESET ? '0 : rb_q[rb_rp_q].resp;
    assign bus.RLAST    = !ARESET && rb_q[rb_rp_q].last;
    assign bus.mem_req  = !ARESET && (state_q == S_BURST) && !ill_q && credit_ok;
    assign bus.mem_addr = ARESET ? '0 : addr_q;
endmodule

// File: doc/axi_mem_rd_engine.md
AXI_MEM_RD_ENGINE -- requirements
Module: axi_mem_rd_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, RDATA/mem_rdata width; legal values 32, 64, 128, 256.
REQ-002 SHALL have parameter ID_WIDTH, default 4, ARID/RID width.
REQ-003 SHALL have parameter AR_DEPTH, default 4, read-address queue depth; power of two, at least 2.
REQ-004 SHALL have port ACLK, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port ARESET, input, 1, synchronous active-high reset sampled on the ACLK rising edge.
REQ-006 SHALL have AR inputs ARID[ID_WIDTH], ARADDR[32], ARLEN[8], ARSIZE[3], ARBURST[2], ARLOCK[2] and ARVALID[1], plus output ARREADY[1].
REQ-007 SHALL have R outputs RID[ID_WIDTH], RDATA[DATA_WIDTH], RRESP[2], RLAST[1] and RVALID[1], plus input RREADY[1].
REQ-008 SHALL have memory-port outputs mem_req[1] and mem_addr[32], and inputs mem_ready[1], mem_rdata[DATA_WIDTH] and mem_err[1].

Function
REQ-009 SHALL accept an AR transfer when ARVALID&ARREADY; ARREADY = queue not full.
REQ-010 SHALL store ID, ADDR, LEN, SIZE, BURST and LOCK in a FIFO of AR_DEPTH entries; up to AR_DEPTH bursts are outstanding.
REQ-011 SHALL implement a beat generator with states IDLE and BURST.
- IDLE to BURST: queue not empty; pop the head and load the beat counter with ARLEN.
- BURST to IDLE: last beat issued and queue empty.
- BURST to BURST (next burst, no bubble): last beat issued and queue not empty.
REQ-012 SHALL assert mem_req in BURST only when R-buffer free slots minus in-flight reads is greater than 0; a beat issues on mem_req&mem_ready.
REQ-013 SHALL treat mem_rdata/mem_err as valid exactly 1 cycle after an issued beat, and write them into the R buffer.
REQ-014 SHALL use a 2-entry R output buffer; no beat is lost or duplicated under any RREADY pattern.
REQ-015 SHALL compute the first beat address as ARADDR aligned down to 2^ARSIZE bytes.
- FIXED: address constant for every beat.
- INCR: address advances by 2^ARSIZE per beat, 32-bit wrap-around.
REQ-016 SHALL, for WRAP, advance by 2^ARSIZE within a window of (ARLEN+1)*2^ARSIZE bytes aligned to that size, returning to the window base past the top.
REQ-017 SHALL return SLVERR (2'b10) with RDATA=0 and no memory access for every beat of an illegal burst.
- Illegal conditions: ARSIZE > log2(DATA_WIDTH/8); ARBURST=2'b11; WRAP with ARLEN not in {1,3,7,15}.
- The full ARLEN+1 beat count is still returned.
REQ-018 SHALL set RRESP per beat.
- SLVERR if mem_err, else EXOKAY (2'b01) if ARLOCK=2'b01, else OKAY (2'b00).
REQ-019 SHALL hold RID at the burst's ARID on every beat and assert RLAST on beat ARLEN only.
REQ-020 SHALL return bursts in acceptance order; beats are not interleaved across IDs.
REQ-021 SHALL keep RVALID, RDATA, RID, RRESP and RLAST stable while RVALID&!RREADY.
REQ-022 SHALL handle simultaneous queue push and pop when full: ARREADY stays 0 that cycle and the pop frees a slot the next cycle.
REQ-023 SHALL support ARLEN=255 with an 8-bit beat counter and no overflow.

Reset
REQ-024 SHALL, on ARESET=1, clear the FIFO, beat generator (IDLE), in-flight count and R buffer within one ACLK edge.
REQ-025 SHALL hold these output values during reset: ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, mem_req=0, mem_addr=0.
REQ-026 SHALL drive ARREADY=1 the first cycle after reset deasserts.
REQ-027 SHALL, if reset is asserted mid-burst, discard remaining beats, in-flight memory data and queued bursts; no stale beat appears after reset.

Configuration
REQ-028 SHALL compile WRAP support in only when macro AXI_MEM_RD_WRAP_EN is defined.
- Defined: WRAP bursts behave per REQ-016.
- Undefined: ARBURST=2'b10 is illegal per REQ-017 (all beats SLVERR, no memory access), and wrap logic is absent.

Verification
REQ-029 SHALL cover: INCR, ARADDR=0x1004, ARSIZE=4, ARLEN=3, RREADY=1 -> mem_addr 0x1000, 0x1010, 0x1020, 0x1030; 4 beats OKAY; RLAST on the 4th only.
REQ-030 SHALL cover (macro defined): WRAP, ARADDR=0x2030, ARSIZE=4, ARLEN=3 -> mem_addr 0x2030, 0x2000, 0x2010, 0x2020.
REQ-031 SHALL cover: AR_DEPTH=4, five back-to-back ARs with RREADY=0 -> ARREADY drops after the 4th acceptance; all 5 bursts return in order once RREADY=1.
REQ-032 SHALL cover: RREADY toggling 1010... over an ARLEN=15 burst -> exactly 16 beats, data stable while stalled, no loss or duplication.
REQ-033 SHALL cover: ARLOCK=01 burst -> RRESP=01 each beat; mem_err=1 on beat 2 -> RRESP=10 on beat 2 only; ARSIZE=5 on a 128-bit bus -> SLVERR on every beat with mem_req never asserted.
REQ-034 SHALL cover: ARESET pulse during beat 3 of an ARLEN=7 burst -> RVALID=0 the following cycle and no remaining beats emitted.
